// File: rtl/uart_pkg.sv
// uart_pkg: shared UART parity encoding, receiver state encoding and baud divider helper
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT} rx_state_e;
  function automatic int uart_divider(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction
endpackage

// File: rtl/uart_os_tick.sv
// uart_os_tick: oversample prescaler with restart, giving a tick strobe and the per-bit tick index
module uart_os_tick #(
  parameter int DIVIDER = 10,
  parameter int OVERSAMPLE = 16,
  localparam int PW = DIVIDER > 1 ? $clog2(DIVIDER) : 1,
  localparam int IW = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart_i,
  output logic          tick_o,
  output logic [IW-1:0] idx_o
);
  logic [PW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  assign tick_o = !restart_i && cnt_q == PW'(DIVIDER - 1);
  assign idx_o  = idx_q;
  // Prescaler and tick index, both zeroed on restart so bit centres follow the start edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (restart_i) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
      idx_q <= idx_q == IW'(OVERSAMPLE - 1) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable oversampling UART receiver with valid/ready holding register
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);
  localparam int DIVIDER = uart_divider(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int IW = $clog2(OVERSAMPLE);
  logic [SYNC_STAGES-1:0] sync_q;
  logic rx_s, rx_prev_q, tick, restart, vote, at_s0, at_s1, at_v, at_end;
  logic [IW-1:0] idx;
  rx_state_e state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, rx_data_q;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] smp_q;
  logic par_q, par_d, serr_q, serr_d, zero_q, zero_d;
  logic done, perr, valid_q, perr_q, ferr_q, ovr_q, drop_q, brk_q;
  uart_os_tick #(.DIVIDER(DIVIDER), .OVERSAMPLE(OVERSAMPLE)) u_tick (
    .clk(clk), .rst_n(rst_n), .restart_i(restart), .tick_o(tick), .idx_o(idx)
  );
  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign at_s0  = tick && idx == IW'(OVERSAMPLE / 2 - 1);
  assign at_s1  = tick && idx == IW'(OVERSAMPLE / 2);
  assign at_v   = tick && idx == IW'(OVERSAMPLE / 2 + 1);
  assign at_end = tick && idx == IW'(OVERSAMPLE - 1);
  assign vote   = (smp_q[0] & smp_q[1]) | (rx_s & (smp_q[0] | smp_q[1]));
  assign perr   = PARITY == PAR_ODD ? ~(^shift_q ^ par_q) : PARITY == PAR_EVEN ? (^shift_q ^ par_q) : 1'b0;
  assign rx_data    = rx_data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign break_det  = brk_q;
  assign busy       = state_q != S_IDLE;
  // Frame FSM: start qualification, data/parity/stop voting and break recovery
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    serr_d  = serr_q;
    zero_d  = zero_q;
    restart = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (rx_prev_q && !rx_s) begin
        state_d = S_START;
        restart = 1'b1;
      end
      S_START: if (at_v && vote) state_d = S_IDLE;
      else if (at_end) begin
        state_d = S_DATA;
        cnt_d   = '0;
        serr_d  = 1'b0;
        zero_d  = 1'b1;
      end
      S_DATA: begin
        if (at_v) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          zero_d  = zero_q & ~vote;
        end
        if (at_end) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(DATA_BITS - 1)) begin
            state_d = PARITY != PAR_NONE ? S_PARITY : S_STOP;
            cnt_d   = '0;
          end
        end
      end
      S_PARITY: begin
        if (at_v) begin
          par_d  = vote;
          zero_d = zero_q & ~vote;
        end
        if (at_end) state_d = S_STOP;
      end
      S_STOP: if (at_v) begin
        serr_d = serr_q | ~vote;
        zero_d = zero_q & ~vote;
        if (cnt_q == 4'(STOP_BITS - 1)) begin
          done    = 1'b1;
          state_d = zero_d ? S_BRK_WAIT : S_IDLE;
        end
      end else if (at_end) cnt_d = cnt_q + 4'd1;
      S_BRK_WAIT: begin
        restart = !rx_s;
        if (at_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // Synchroniser, mid-bit samples and FSM state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      smp_q     <= '0;
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_q     <= 1'b0;
      serr_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev_q <= rx_s;
      if (at_s0) smp_q[0] <= rx_s;
      if (at_s1) smp_q[1] <= rx_s;
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      serr_q    <= serr_d;
      zero_q    <= zero_d;
    end
  // Holding register: load on completion when free, otherwise drop and remember it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      drop_q    <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      brk_q <= done && zero_d;
      if (done && !zero_d && (!valid_q || rx_ready)) begin
        rx_data_q <= shift_q;
        valid_q   <= 1'b1;
        perr_q    <= perr;
        ferr_q    <= serr_d;
        ovr_q     <= drop_q;
        drop_q    <= 1'b0;
      end else begin
        if (done && !zero_d) drop_q <= 1'b1;
        if (rx_ready) valid_q <= 1'b0;
      end
    end
endmodule
